// File: rtl/rs_encoder_pkg.sv
// Shared helpers for the Reed-Solomon encoder array: index widths that stay
// at least one bit wide even for degenerate (single unit / single line) configs.
package rs_encoder_pkg;

  function automatic int rs_unit_w(input int num_units);
    return (num_units > 1) ? $clog2(num_units) : 1;
  endfunction

  function automatic int line_cnt_w(input int num_lines);
    return (num_lines > 1) ? $clog2(num_lines) : 1;
  endfunction

endpackage

// File: rtl/bsg_decode_with_v.sv
// Index-to-one-hot decoder gated by a valid; all zeros when v_i is low.
module bsg_decode_with_v #(
  parameter  int num_out_p = 16,
  localparam int lg_w      = (num_out_p > 1) ? $clog2(num_out_p) : 1
) (
  input  logic [lg_w-1:0]      i,
  input  logic                 v_i,
  output logic [num_out_p-1:0] o
);

  // one bit per output, set only for the selected index while valid
  always_comb begin
    o = '0;
    for (int k = 0; k < num_out_p; k++) o[k] = v_i && (i == lg_w'(k));
  end

endmodule

// File: rtl/rs_line_1_to_16.sv
// Round-robin line distributor feeding the RS encoder array: NUM_LINES
// consecutive lines go to one unit, then the pointer moves to the next unit.
// Units are never skipped so the output-side reducer can rebuild arrival order.
module rs_line_1_to_16
  import rs_encoder_pkg::*;
#(
  parameter  int NUM_RS_UNITS = 16,
  parameter  int DATA_W       = 256,
  parameter  int NUM_LINES    = 8,
  localparam int RS_UNIT_W    = rs_unit_w(NUM_RS_UNITS),
  localparam int LINE_CNT_W   = line_cnt_w(NUM_LINES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    src_distrib_line_val,
  input  logic [DATA_W-1:0]       src_distrib_line_data,
  output logic                    distrib_src_line_rdy,
  output logic [NUM_RS_UNITS-1:0] distrib_dst_line_vals,
  output logic [DATA_W-1:0]       distrib_dst_line_data,
  input  logic [NUM_RS_UNITS-1:0] dst_distrib_line_rdys,
  output logic [RS_UNIT_W-1:0]    distrib_cur_unit,
  output logic [LINE_CNT_W-1:0]   distrib_line_cnt
);

  localparam logic [RS_UNIT_W-1:0]  LAST_UNIT = RS_UNIT_W'(NUM_RS_UNITS - 1);
  localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(NUM_LINES - 1);

  logic                  out_val;
  logic [DATA_W-1:0]     out_data;
  logic [RS_UNIT_W-1:0]  out_unit;
  logic [RS_UNIT_W-1:0]  cur_unit;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic                  drain;
  logic                  acc;

  // only the addressed unit's ready can drain the held line
  assign drain = out_val & dst_distrib_line_rdys[out_unit];
  assign distrib_src_line_rdy = ~out_val | drain;
  assign acc   = src_distrib_line_val & distrib_src_line_rdy;

  assign distrib_dst_line_data = out_data;
  assign distrib_cur_unit      = cur_unit;
  assign distrib_line_cnt      = line_cnt;

  // single-entry output register: reload on accept, clear on drain-only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val  <= 1'b0;
      out_data <= '0;
      out_unit <= '0;
    end else if (acc) begin
      out_val  <= 1'b1;
      out_data <= src_distrib_line_data;
      out_unit <= cur_unit;
    end else if (drain) begin
      out_val  <= 1'b0;
    end
  end

  // dispatch pointer advances only on accepted lines; wraps at block/array end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_unit <= '0;
      line_cnt <= '0;
    end else if (acc) begin
      if (line_cnt == LAST_LINE) begin
        line_cnt <= '0;
        cur_unit <= (cur_unit == LAST_UNIT) ? '0 : cur_unit + 1'b1;
      end else begin
        line_cnt <= line_cnt + 1'b1;
      end
    end
  end

  bsg_decode_with_v #(.num_out_p(NUM_RS_UNITS)) u_dec (
    .i   (out_unit),
    .v_i (out_val),
    .o   (distrib_dst_line_vals)
  );

endmodule

// File: doc/rs_line_1_to_16.md
# rs_line_1_to_16

Front-end distributor for the Reed-Solomon encoder array: accepts one stream of data lines and dispatches it to NUM_RS_UNITS encoder units in strict round-robin, NUM_LINES consecutive lines (one codeword block) per unit. It drives the one-hot per-unit valids and the shared line bus that feed the encoder array. Its dispatch order is the same unit order used by the 16-to-1 reducer on the output side, so blocks leave the array in arrival order.

## Interface
- NUM_RS_UNITS, 16, number of encoder units served
- DATA_W, 256, line width in bits
- NUM_LINES, 8, lines per block sent to one unit (>=1)

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- src_distrib_line_val  in  1  upstream line valid
- src_distrib_line_data  in  DATA_W  upstream line
- distrib_src_line_rdy  out  1  upstream ready
- distrib_dst_line_vals  out  NUM_RS_UNITS  one-hot valid to the target unit
- distrib_dst_line_data  out  DATA_W  shared line bus to all units
- dst_distrib_line_rdys  in  NUM_RS_UNITS  per-unit ready
- distrib_cur_unit  out  max(1,clog2(NUM_RS_UNITS))  unit receiving the next accepted line
- distrib_line_cnt  out  max(1,clog2(NUM_LINES))  lines of the current block already accepted

## Operation
- State: out_val, out_data, out_unit (output register); cur_unit, line_cnt (dispatch pointer).
- distrib_dst_line_vals = out_val ? (1 << out_unit) : 0; distrib_dst_line_data = out_data.
- Drain: drain = out_val & dst_distrib_line_rdys[out_unit]; readies of other units are ignored.
- distrib_src_line_rdy = ~out_val | drain (combinational through the target ready; no other path).
- Accept: acc = src_distrib_line_val & distrib_src_line_rdy; load out_data <= src data, out_unit <= cur_unit, out_val <= 1.
- Drain without accept: out_val <= 0. Drain and accept in the same cycle: register reloaded, out_val stays 1.
- Pointer on acc: if line_cnt == NUM_LINES-1, line_cnt <= 0 and cur_unit <= (cur_unit == NUM_RS_UNITS-1) ? 0 : cur_unit+1; else line_cnt+1.
- A stalled unit stalls the whole stream; units are never skipped (ordering invariant with reducer).
- NUM_LINES == 1: advance unit on every accept. NUM_RS_UNITS == 1: cur_unit constant 0.
- Data is not modified; no data-dependent behaviour.

## Timing
- Reset values: out_val 0, all distrib_dst_line_vals 0, distrib_dst_line_data 0, cur_unit 0, line_cnt 0; distrib_src_line_rdy 1 after reset.
- Reset mid-block: partial block discarded, pointer returns to unit 0, line 0; held output line dropped.
- Latency: line accepted in cycle N appears on distrib_dst_line_vals in cycle N+1.
- Throughput: one line per cycle sustained when target readies stay high, including across block boundaries (unit k last line and unit k+1 first line on consecutive cycles).
- Output valid/data held stable until drained (valid/ready, no retraction).

## Structure
- Shared package rs_encoder_pkg: RS_UNIT_W = max(1,clog2(NUM_RS_UNITS)) and LINE_CNT_W = max(1,clog2(NUM_LINES)) helper functions; no new typedefs.
- One-hot valid generated with bsg_decode_with_v (unit index, v = out_val); no other sub-module.

## Test plan
- Config NUM_RS_UNITS=4, NUM_LINES=2, all readies 1, 10 lines 0x0..0x9 back-to-back -> vals 0001,0001,0010,0010,0100,0100,1000,1000,0001,0001 on cycles 1..10; data matches; cur_unit wraps 3->0.
- Unit 1 ready held 0 for 5 cycles while line 0x2 targets it -> vals=0010 and data=0x2 stable, src rdy 0, no line accepted; resumes next cycle after ready rises.
- Only non-target units ready (rdys=1101, target unit 1) -> no drain, no skip; line 0x2 not delivered to any other unit.
- Upstream valid toggling every other cycle, readies 1 -> each line delivered exactly once, out_val low in gap cycles, pointer counts only accepted lines.
- rst asserted asynchronously after 3 lines (mid-block on unit 1) -> vals 0 immediately, cur_unit 0, line_cnt 0; next line goes to unit 0.
- Default config, 16*8+1 lines with random readies -> scoreboard: line i goes to unit (i/8)%16, order preserved, no loss or duplication.
